counter_cmd_decoder: RTL

COUNTER_CMD_DECODER -- requirements
Module: counter_cmd_decoder

---
 rtl/counter_cmd_pkg.sv | 19 +
 rtl/sat_counter.sv | 22 ++
 rtl/counter_cmd_decoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/counter_cmd_pkg.sv
// Shared types and defaults for the counter command decoder: FSM states,
// decoded command kinds and default widths.
package counter_cmd_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CW    = 16;

    typedef enum logic {
        ST_UNSYNC = 1'b0,
        ST_SYNC   = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        CMD_UP     = 2'd0,
        CMD_DOWN   = 2'd1,
        CMD_PRESET = 2'd2
    } cmd_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones; clear beats a same-cycle increment.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CW{1'b1}})) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/counter_cmd_decoder.sv
// Watches an up/down/preset counter and reconstructs the command that moved it
// between consecutive samples, with a one-deep output register and statistics.
module counter_cmd_decoder
    import counter_cmd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = DEFAULT_CW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_valid,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic             cmd_preset,
    output logic             cmd_updown,
    output logic [WIDTH-1:0] cmd_data,
    output logic             synced,
    output logic [CW-1:0]    up_count,
    output logic [CW-1:0]    down_count,
    output logic [CW-1:0]    preset_count,
    output logic             overflow,
    input  logic             clear_stats,
    output logic             fsm_state
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] prev_next;
    logic [WIDTH-1:0] prev_inc;
    logic [WIDTH-1:0] prev_dec;
    cmd_t             cmd_kind;
    logic             new_cmd;
    logic             load;
    logic             drop;

    assign prev_inc = prev + WIDTH'(1);
    assign prev_dec = prev - WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_UNSYNC;
            prev  <= '0;
        end else begin
            state <= state_next;
            prev  <= prev_next;
        end
    end

    // Priority up > down > preset also settles WIDTH=1, where +1 and -1 coincide.
    always_comb begin
        state_next = state;
        prev_next  = prev;
        new_cmd    = 1'b0;
        cmd_kind   = CMD_PRESET;
        if (cnt_in == prev_inc) begin
            cmd_kind = CMD_UP;
        end else if (cnt_in == prev_dec) begin
            cmd_kind = CMD_DOWN;
        end
        if (cnt_valid) begin
            prev_next = cnt_in;
            case (state)
                ST_UNSYNC: state_next = ST_SYNC;
                ST_SYNC:   new_cmd    = 1'b1;
                default:   state_next = ST_UNSYNC;
            endcase
        end
    end

    assign synced    = (state == ST_SYNC);
    assign fsm_state = state;

    // Handshake: a command transfers at an edge where cmd_valid && cmd_ready;
    // once cmd_valid rises, cmd_valid and cmd_* stay frozen until that transfer.
    // A new command arriving while the held one is stalled is dropped, not queued.
    assign load = new_cmd && (!cmd_valid || cmd_ready);
    assign drop = new_cmd && cmd_valid && !cmd_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_valid  <= 1'b0;
            cmd_preset <= 1'b0;
            cmd_updown <= 1'b0;
            cmd_data   <= '0;
        end else if (load) begin
            cmd_valid  <= 1'b1;
            cmd_preset <= (cmd_kind == CMD_PRESET);
            cmd_updown <= (cmd_kind == CMD_UP);
            cmd_data   <= cnt_in;
        end else if (cmd_valid && cmd_ready) begin
            cmd_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (clear_stats) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    // Statistics count every decoded command, including dropped ones.
    sat_counter #(.CW(CW)) u_up_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear_stats),
        .inc   (new_cmd && (cmd_kind == CMD_UP)),
        .count (up_count)
    );

    sat_counter #(.CW(CW)) u_down_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear_stats),
        .inc   (new_cmd && (cmd_kind == CMD_DOWN)),
        .count (down_count)
    );

    sat_counter #(.CW(CW)) u_preset_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear_stats),
        .inc   (new_cmd && (cmd_kind == CMD_PRESET)),
        .count (preset_count)
    );

endmodule
